// File: rtl/reg_file_if.sv
// ---------------------------------------------------------------------------
// reg_file_if: decode-stage register-file bus.
//   master : ID-stage / write-back side. Drives the read addresses and the
//            write request; receives read data and the debug write count.
//   slave  : the register file itself.
// Signals:
//   ReadReg1/ReadReg2  read addresses (Rn, Reg2Loc output)
//   RegWrite/WriteReg/WriteData  write-back write request
//   ReadData1/ReadData2  combinational read data (with write-through bypass)
//   WriteCount  committed writes since reset, wraps at 16 bits
// ---------------------------------------------------------------------------
interface reg_file_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] ReadReg1;
    logic [ADDR_WIDTH-1:0] ReadReg2;
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] WriteReg;
    logic [DATA_WIDTH-1:0] WriteData;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [15:0]           WriteCount;

    modport master (
        output ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData,
        input  ReadData1, ReadData2, WriteCount
    );

    modport slave (
        input  ReadReg1, ReadReg2, RegWrite, WriteReg, WriteData,
        output ReadData1, ReadData2, WriteCount
    );
endinterface

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file: 32 x 64-bit LEGv8 general-purpose register file.
//   Two combinational read ports, one write port committed on rising CLK.
//   Index ZERO_REG (XZR) always reads 0 and discards writes.
//   A pending write is forwarded to a matching read port in the same cycle,
//   so ID/EX captures the new value on the edge that commits the write.
// Ports:
//   CLK    rising-edge clock
//   RESET  asynchronous, active-high; clears all entries and WriteCount
//   bus    reg_file_if slave modport (read/write ports, WriteCount)
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 31
) (
    input  logic         CLK,
    input  logic         RESET,
    reg_file_if.slave    bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [15:0]                      count_q, count_d;
    logic                             wr_en;
    logic [DATA_WIDTH-1:0]            rd1, rd2;

    // Writes aimed at XZR are dropped entirely, including for the bypass.
    assign wr_en = bus.RegWrite && (bus.WriteReg != ZERO_ADDR);

    always_comb begin
        regs_d  = regs_q;
        count_d = count_q;
        if (wr_en) begin
            regs_d[bus.WriteReg] = bus.WriteData;
            count_d              = count_q + 16'd1;   // wraps naturally
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            regs_q  <= '0;
            count_q <= '0;
        end else begin
            regs_q  <= regs_d;
            count_q <= count_d;
        end
    end

    // Read priority (lowest to highest): stored value, bypass, XZR, reset.
    // Reset must also mask the bypass so outputs are 0 while it is held.
    always_comb begin
        rd1 = regs_q[bus.ReadReg1];
        if (wr_en && (bus.WriteReg == bus.ReadReg1)) rd1 = bus.WriteData;
        if (bus.ReadReg1 == ZERO_ADDR)               rd1 = '0;
        if (RESET)                                   rd1 = '0;
    end

    always_comb begin
        rd2 = regs_q[bus.ReadReg2];
        if (wr_en && (bus.WriteReg == bus.ReadReg2)) rd2 = bus.WriteData;
        if (bus.ReadReg2 == ZERO_ADDR)               rd2 = '0;
        if (RESET)                                   rd2 = '0;
    end

    assign bus.ReadData1  = rd1;
    assign bus.ReadData2  = rd2;
    assign bus.WriteCount = count_q;
endmodule

// File: tb/tb_reg_file.sv
`timescale 1ns/100ps
module tb_reg_file;
    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   failures = 0;

    reg_file_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5)) bus ();

    reg_file #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .ZERO_REG(31)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    // Inputs change on the falling edge; writes commit on the next rising edge.
    task automatic do_write(input logic [4:0] addr, input logic [63:0] data);
        @(negedge CLK);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = addr;
        bus.WriteData = data;
        @(posedge CLK);
        #1;
        bus.RegWrite  = 1'b0;
    endtask

    task automatic test_reset;
        do_write(5'd7, 64'h55);
        @(posedge CLK);
        #2;
        RESET = 1'b1;          // mid-cycle, no clock edge needed
        #1;
        checks++;
        if (bus.WriteCount !== 16'd0) begin
            failures++;
            $display("FAIL reset_count actual=%h expected=0000", bus.WriteCount);
        end
        for (int a = 0; a < 32; a++) begin
            bus.ReadReg1 = 5'(a);
            bus.ReadReg2 = 5'(31 - a);
            #0.1;
            checks++;
            if (bus.ReadData1 !== 64'd0 || bus.ReadData2 !== 64'd0) begin
                failures++;
                $display("FAIL reset_read addr=%0d actual1=%h actual2=%h expected=0",
                         a, bus.ReadData1, bus.ReadData2);
            end
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_write_read;
        do_write(5'd5, 64'h0123_4567_89AB_CDEF);
        @(negedge CLK);
        bus.ReadReg1 = 5'd5;
        bus.ReadReg2 = 5'd5;
        #1;
        checks++;
        if (bus.ReadData1 !== 64'h0123_4567_89AB_CDEF || bus.ReadData2 !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL write_read actual1=%h actual2=%h expected=0123456789abcdef",
                     bus.ReadData1, bus.ReadData2);
        end
        checks++;
        if (bus.WriteCount !== 16'd1) begin
            failures++;
            $display("FAIL write_read_count actual=%0d expected=1", bus.WriteCount);
        end
    endtask

    task automatic test_xzr;
        @(negedge CLK);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd31;
        bus.WriteData = '1;
        bus.ReadReg1  = 5'd31;
        bus.ReadReg2  = 5'd5;
        #1;
        checks++;
        if (bus.ReadData1 !== 64'd0) begin
            failures++;
            $display("FAIL xzr_no_bypass actual=%h expected=0", bus.ReadData1);
        end
        checks++;
        if (bus.ReadData2 !== 64'h0123_4567_89AB_CDEF) begin
            failures++;
            $display("FAIL xzr_other_port actual=%h expected=0123456789abcdef", bus.ReadData2);
        end
        @(posedge CLK);
        #1;
        bus.RegWrite = 1'b0;
        bus.ReadReg2 = 5'd31;
        #1;
        checks++;
        if (bus.ReadData1 !== 64'd0 || bus.ReadData2 !== 64'd0) begin
            failures++;
            $display("FAIL xzr_read actual1=%h actual2=%h expected=0", bus.ReadData1, bus.ReadData2);
        end
        checks++;
        if (bus.WriteCount !== 16'd1) begin
            failures++;
            $display("FAIL xzr_count actual=%0d expected=1", bus.WriteCount);
        end
    endtask

    task automatic test_bypass;
        do_write(5'd9, 64'h10);
        do_write(5'd3, 64'h7);
        @(negedge CLK);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd9;
        bus.WriteData = 64'h20;
        bus.ReadReg1  = 5'd9;
        bus.ReadReg2  = 5'd3;
        #1;
        checks++;
        if (bus.ReadData1 !== 64'h20 || bus.ReadData2 !== 64'h7) begin
            failures++;
            $display("FAIL bypass actual1=%h actual2=%h expected1=20 expected2=7",
                     bus.ReadData1, bus.ReadData2);
        end
        bus.ReadReg2 = 5'd9;   // both ports bypass at once
        #1;
        checks++;
        if (bus.ReadData1 !== 64'h20 || bus.ReadData2 !== 64'h20) begin
            failures++;
            $display("FAIL bypass_dual actual1=%h actual2=%h expected=20",
                     bus.ReadData1, bus.ReadData2);
        end
        @(posedge CLK);
        #1;
        bus.RegWrite = 1'b0;
        #1;
        checks++;
        if (bus.ReadData1 !== 64'h20) begin
            failures++;
            $display("FAIL bypass_commit actual=%h expected=20", bus.ReadData1);
        end
        checks++;
        if (bus.WriteCount !== 16'd4) begin
            failures++;
            $display("FAIL bypass_count actual=%0d expected=4", bus.WriteCount);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge CLK);
        bus.RegWrite  = 1'b1;
        bus.WriteReg  = 5'd4;
        bus.WriteData = 64'hAA;
        @(posedge CLK);
        RESET = 1'b1;          // coincident with the write edge
        @(negedge CLK);
        RESET = 1'b0;
        bus.RegWrite = 1'b0;
        bus.ReadReg1 = 5'd4;
        #1;
        checks++;
        if (bus.ReadData1 !== 64'd0) begin
            failures++;
            $display("FAIL reset_mid_data actual=%h expected=0", bus.ReadData1);
        end
        checks++;
        if (bus.WriteCount !== 16'd0) begin
            failures++;
            $display("FAIL reset_mid_count actual=%0d expected=0", bus.WriteCount);
        end
        do_write(5'd4, 64'hBB);
        #1;
        checks++;
        if (bus.ReadData1 !== 64'hBB) begin
            failures++;
            $display("FAIL reset_mid_rewrite actual=%h expected=bb", bus.ReadData1);
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_q [31];
        logic [31:0] iv;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        RESET = 1'b0;
        for (int a = 0; a < 31; a++) exp_q[a] = '0;
        bus.RegWrite = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            iv = 32'(i);
            bus.WriteReg  = 5'(i % 31);
            bus.WriteData = {iv ^ 32'hDEAD_0000, ~iv};
            exp_q[i % 31] = {iv ^ 32'hDEAD_0000, ~iv};
            if (i == 65535) begin
                #1;
                checks++;
                if (bus.WriteCount !== 16'hFFFF) begin
                    failures++;
                    $display("FAIL count_max actual=%h expected=ffff", bus.WriteCount);
                end
            end
            @(negedge CLK);
        end
        bus.RegWrite = 1'b0;
        #1;
        checks++;
        if (bus.WriteCount !== 16'h0000) begin
            failures++;
            $display("FAIL count_wrap actual=%h expected=0000", bus.WriteCount);
        end
        for (int a = 0; a < 31; a++) begin
            bus.ReadReg1 = 5'(a);
            bus.ReadReg2 = 5'(30 - a);
            #0.1;
            checks++;
            if (bus.ReadData1 !== exp_q[a] || bus.ReadData2 !== exp_q[30 - a]) begin
                failures++;
                $display("FAIL b2b_read addr=%0d actual1=%h expected1=%h actual2=%h expected2=%h",
                         a, bus.ReadData1, exp_q[a], bus.ReadData2, exp_q[30 - a]);
            end
        end
    endtask

    initial begin
        RESET         = 1'b1;
        bus.ReadReg1  = '0;
        bus.ReadReg2  = '0;
        bus.RegWrite  = 1'b0;
        bus.WriteReg  = '0;
        bus.WriteData = '0;
        #12;
        @(negedge CLK);
        RESET = 1'b0;
        test_reset;
        test_write_read;
        test_xzr;
        test_bypass;
        test_reset_mid;
        test_back_to_back;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- 32-entry general-purpose register file for the LEGv8 pipeline.
- Sits in the decode stage, directly downstream of Reg2Loc.
- Read port 1 is addressed by Rn (IF/ID pipeline register bits [9:5]).
- Read port 2 is addressed by the Reg2Loc output.
- The single write port is driven by the write-back stage.
- Read data feeds the ID/EX pipeline register.

Parameters:
- DATA_WIDTH, 64, width of each register and of all data ports.
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH = 32.
- ZERO_REG, 31, index of XZR; always reads zero, writes discarded.

Ports:
- CLK  input  1  single clock, all state updates on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ReadReg1  input  ADDR_WIDTH  read port 1 address (Rn).
- ReadReg2  input  ADDR_WIDTH  read port 2 address (from Reg2Loc).
- RegWrite  input  1  write enable from write-back stage.
- WriteReg  input  ADDR_WIDTH  write address (Rd from MEM/WB).
- WriteData  input  DATA_WIDTH  write data from write-back mux.
- ReadData1  output  DATA_WIDTH  contents selected by ReadReg1.
- ReadData2  output  DATA_WIDTH  contents selected by ReadReg2.
- WriteCount  output  16  number of committed writes since reset (debug).

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high on RESET.
- Reset:
  - While RESET=1, all 32 entries = 0, WriteCount = 0, ReadData1/2 = 0.
  - Effect is immediate, independent of CLK.
  - Reset asserted mid-write (same edge as RegWrite=1) wins: the entry stays 0 and the count stays 0.
- Write:
  - On rising CLK with RESET=0 and RegWrite=1 and WriteReg != ZERO_REG: entry[WriteReg] <= WriteData and WriteCount <= WriteCount+1.
  - WriteReg == ZERO_REG: no store, count unchanged.
  - RegWrite=0: no state change.
- Read:
  - Combinational, zero latency. ReadDataN = entry[ReadRegN].
  - ReadRegN == ZERO_REG forces 0 regardless of stored or bypassed values.
- Write-through bypass (replaces a half-cycle-write register file):
  - If RegWrite=1, WriteReg != ZERO_REG and WriteReg == ReadRegN, then ReadDataN = WriteData in the same cycle, before the edge.
  - Both ports may bypass simultaneously when ReadReg1 == ReadReg2 == WriteReg.
  - Bypass is purely combinational and never gated by CLK.
- Width rules:
  - No truncation; full DATA_WIDTH stored and returned.
  - WriteCount wraps from 0xFFFF to 0x0000 with no saturation.
- Timing:
  - ReadData1/2 are captured by ID/EX on the same CLK edge that commits a write-back write.
  - Bypass guarantees ID/EX sees the new value with no stall.
- X-handling:
  - Addresses are always 5-bit decoded; no out-of-range case exists.
  - Reads of never-written entries return 0.

Test Plan:
- Reset → read: assert RESET asynchronously mid-cycle → ReadData1/2 = 0 for all 32 addresses and WriteCount = 0, without waiting for a CLK edge.
- Write then read: write X5 = 0x0123_4567_89AB_CDEF, then on the next cycle set ReadReg1 = 5, ReadReg2 = 5 → both outputs = 0x0123_4567_89AB_CDEF and WriteCount = 1.
- XZR protection: write 0xFFFF_FFFF_FFFF_FFFF to X31, then read X31 on both ports → 0 and WriteCount unchanged. While the write is pending with ReadReg1 = 31, ReadData1 = 0 (no bypass).
- Same-cycle bypass: X9 holds 0x10. Drive RegWrite=1, WriteReg=9, WriteData=0x20, ReadReg1=9, ReadReg2=3 (X3 = 0x7) → ReadData1 = 0x20 before the edge, ReadData2 = 0x7. After the edge, X9 = 0x20.
- Reset mid-operation: assert RESET coincident with a write of 0xAA to X4 → after release, X4 reads 0, WriteCount = 0, and a subsequent write of 0xBB to X4 reads back 0xBB.
- Counter wrap and back-to-back writes: perform 65536 writes to rotating addresses 0..30 → WriteCount returns to 0x0000. The final 31 written values read back correctly on both ports.
